// File: rtl/systolic_array_v2.sv
// rtl/systolic_array_v2.sv - output-stationary signed MAC systolic array
//
// Purpose: N_BANKS x N_COLS grid of signed multiply-accumulate PEs. Weights and a
// valid/last token enter at column 0 and move one column right per cycle. Features
// are delayed c cycles per column, so every PE pairs operands from the same beat.
// A result is written to dout on each last-flagged token, then the accumulator clears.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cfg_load, cfg_len,
//   cfg_tiles            latch beats-per-accumulation / tiles-per-run (IDLE only, 0 -> 1)
//   start                begin a run (IDLE only)
//   in_valid, weight,
//   feature              one input beat; bank b / column c packed at [i*I_WIDTH +: I_WIDTH]
//   dout, dout_valid     per-PE results (index b*N_COLS+c), per-column one-cycle strobe
//   busy, done, ovf      run in progress, end-of-run pulse, sticky saturation flag
module systolic_array_v2 #(
  parameter int N_BANKS = 2,
  parameter int N_COLS  = 4,
  parameter int I_WIDTH = 16,
  parameter int O_WIDTH = 33,
  parameter int LEN_W   = 14,
  parameter int TILE_W  = 8,
  parameter int SAT     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_load,
  input  logic [LEN_W-1:0]                    cfg_len,
  input  logic [TILE_W-1:0]                   cfg_tiles,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [N_BANKS*I_WIDTH-1:0]          weight,
  input  logic [N_COLS*I_WIDTH-1:0]           feature,
  output logic [N_BANKS*N_COLS*O_WIDTH-1:0]   dout,
  output logic [N_COLS-1:0]                   dout_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                ovf
);

  localparam int PW = 2 * I_WIDTH;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;
  localparam logic [TILE_W-1:0] TILE_ONE = 1;
  localparam logic signed [O_WIDTH-1:0] ACC_MAX = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [O_WIDTH-1:0] ACC_MIN = {1'b1, {(O_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0]  len_q, beat_cnt;
  logic [TILE_W-1:0] tiles_q, tile_cnt;
  logic              accept, start_ok, beat_last, tile_last;

  // Token pipeline: valid, last-of-accumulation, last-of-run; plus weights per column.
  logic [N_COLS-1:0]          tok_v, tok_l, tok_f;
  logic signed [I_WIDTH-1:0]  w_p  [N_COLS][N_BANKS];
  logic signed [I_WIDTH-1:0]  in_f [N_COLS];
  logic signed [I_WIDTH-1:0]  f_col [N_COLS];
  logic [N_BANKS*N_COLS-1:0]  pe_ovf;

  assign accept    = (state == S_RUN) && in_valid;
  assign start_ok  = (state == S_IDLE) && start;
  assign beat_last = (beat_cnt == len_q - LEN_ONE);
  assign tile_last = (tile_cnt == tiles_q - TILE_ONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (accept && beat_last && tile_last) state_nx = S_DRAIN;
      // done is registered, so leaving DRAIN one cycle after it keeps busy high with done.
      S_DRAIN: if (done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= LEN_ONE;
      tiles_q  <= TILE_ONE;
      beat_cnt <= '0;
      tile_cnt <= '0;
    end else begin
      state <= state_nx;
      // Config is latched on the same edge that start is taken; counters compare
      // against it only from the following cycle, so start sees the new values.
      if ((state == S_IDLE) && cfg_load) begin
        len_q   <= (cfg_len == '0) ? LEN_ONE : cfg_len;
        tiles_q <= (cfg_tiles == '0) ? TILE_ONE : cfg_tiles;
      end
      if (start_ok) begin
        beat_cnt <= '0;
        tile_cnt <= '0;
      end else if (accept) begin
        if (beat_last) begin
          beat_cnt <= '0;
          tile_cnt <= tile_cnt + TILE_ONE;
        end else begin
          beat_cnt <= beat_cnt + LEN_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_v <= '0;
      tok_l <= '0;
      tok_f <= '0;
      for (int c = 0; c < N_COLS; c++) begin
        in_f[c] <= '0;
        for (int b = 0; b < N_BANKS; b++) w_p[c][b] <= '0;
      end
    end else begin
      tok_v[0] <= accept;
      tok_l[0] <= accept && beat_last;
      tok_f[0] <= accept && beat_last && tile_last;
      if (accept) begin
        for (int b = 0; b < N_BANKS; b++) w_p[0][b] <= weight[b*I_WIDTH +: I_WIDTH];
        for (int c = 0; c < N_COLS; c++) in_f[c] <= feature[c*I_WIDTH +: I_WIDTH];
      end
      for (int c = 1; c < N_COLS; c++) begin
        tok_v[c] <= tok_v[c-1];
        tok_l[c] <= tok_l[c-1];
        tok_f[c] <= tok_f[c-1];
        for (int b = 0; b < N_BANKS; b++) w_p[c][b] <= w_p[c-1][b];
      end
    end
  end

  // Feature skew: column c sees its feature c cycles after the input register.
  for (genvar c = 0; c < N_COLS; c++) begin : g_skew
    if (c == 0) begin : g_direct
      assign f_col[c] = in_f[c];
    end else begin : g_delay
      logic signed [I_WIDTH-1:0] sr [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < c; d++) sr[d] <= '0;
        end else begin
          sr[0] <= in_f[c];
          for (int d = 1; d < c; d++) sr[d] <= sr[d-1];
        end
      end
      assign f_col[c] = sr[c-1];
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      logic signed [PW-1:0]      prod;
      logic signed [O_WIDTH-1:0] acc, dout_r, res;
      logic        [O_WIDTH:0]   sum;
      logic                      pos_ovf, neg_ovf;

      assign prod = w_p[c][b] * f_col[c];
      // One guard bit: the two top bits disagree exactly when the O_WIDTH sum overflowed.
      assign sum  = {acc[O_WIDTH-1], acc} + {{(O_WIDTH+1-PW){prod[PW-1]}}, prod};
      assign pos_ovf = ~sum[O_WIDTH] &  sum[O_WIDTH-1];
      assign neg_ovf =  sum[O_WIDTH] & ~sum[O_WIDTH-1];

      always_comb begin
        res = sum[O_WIDTH-1:0];
        if (SAT != 0) begin
          if (pos_ovf)      res = ACC_MAX;
          else if (neg_ovf) res = ACC_MIN;
        end
      end

      assign pe_ovf[b*N_COLS+c] = (SAT != 0) && tok_v[c] && (pos_ovf || neg_ovf);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc    <= '0;
          dout_r <= '0;
        end else if (tok_v[c]) begin
          if (tok_l[c]) begin
            dout_r <= res;
            acc    <= '0;
          end else begin
            acc <= res;
          end
        end
      end

      assign dout[(b*N_COLS+c)*O_WIDTH +: O_WIDTH] = dout_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= tok_v & tok_l;
      done       <= tok_v[N_COLS-1] & tok_l[N_COLS-1] & tok_f[N_COLS-1];
      if (start_ok)     ovf <= 1'b0;
      else if (|pe_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: doc/systolic_array_v2.md
# systolic_array_v2

Parametrised output-stationary systolic array: N_BANKS weight channels by N_COLS feature columns of signed MAC PEs, with a built-in column enable/skew chain, a programmable accumulation length and tile count, and a single-cycle output register per column. It replaces the fixed 2×4, 3-row bank/DFSM arrangement as the compute core of the convolution datapath. Feature and weight buffers feed it; the output writeback stage drains it.

## Interface
- N_BANKS, 2: PE rows, one output channel per bank.
- N_COLS, 4: PE columns, one feature stream per column.
- I_WIDTH, 16: signed weight/feature width.
- O_WIDTH, 33: signed accumulator/output width; must be ≥ 2*I_WIDTH.
- LEN_W, 14: width of the accumulation-length config field.
- TILE_W, 8: width of the tile-count config field.
- SAT, 0: 1 = saturating accumulation, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  latch cfg_len/cfg_tiles; honoured only in IDLE.
- cfg_len  in  LEN_W  beats per accumulation; 0 is treated as 1.
- cfg_tiles  in  TILE_W  tiles per run; 0 is treated as 1.
- start  in  1  begin run; honoured only in IDLE.
- in_valid  in  1  one beat of weights and features present.
- weight  in  N_BANKS*I_WIDTH  bank b at bits [b*I_WIDTH +: I_WIDTH].
- feature  in  N_COLS*I_WIDTH  column c at bits [c*I_WIDTH +: I_WIDTH].
- dout  out  N_BANKS*N_COLS*O_WIDTH  PE(b,c) at index b*N_COLS+c.
- dout_valid  out  N_COLS  per-column one-cycle result strobe.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- ovf  out  1  sticky overflow flag (SAT=1 only; always 0 when SAT=0).

## Operation
- States: IDLE → (start) RUN → (last beat of last tile accepted) DRAIN → (column N_COLS-1 emits) IDLE.
- Config registers reset to len=1, tiles=1; cfg_load in RUN/DRAIN is ignored; start and cfg_load on the same IDLE cycle: config is latched first, start then uses the new values.
- in_valid is accepted only in RUN; ignored in IDLE and DRAIN. Gaps in in_valid stall the beat counter; the pipeline carries valid tokens, so gaps propagate as bubbles.
- Input stage: accepted beat registered with a valid token and a last flag (beat counter == len-1). Beat counter wraps to 0 on last; tile counter increments on last; final tile's last → DRAIN.
- Weights and the valid/last token shift one column right per cycle. Feature c is delayed internally by c cycles, so PE(b,c) always pairs weight[b] and feature[c] from the same accepted beat.
- PE: product = signed weight × signed feature (2*I_WIDTH), sign-extended to O_WIDTH. On a token with last=0: acc ← acc + product. On last=1: dout(b,c) ← acc + product, acc ← 0, dout_valid[c] pulses. Back-to-back tiles need no bubble.
- SAT=1: sum clamps to ±(2^(O_WIDTH-1)) range limits, and ovf sets. ovf clears on accepted start.
- dout holds its value until the next write for that column.

## Timing
- Reset: state IDLE, all accumulators, pipelines, counters, dout, dout_valid, busy, done, ovf = 0.
- Beat accepted at edge k → input register at k, PE column c accumulates at edge k+1+c.
- Last beat at edge k → dout column c and dout_valid[c] update at edge k+1+c (valid high for the cycle after). Latency to column c = c+1 cycles.
- done pulses in the same cycle as the final dout_valid[N_COLS-1]; busy drops the cycle after.
- busy rises the cycle after an accepted start.
- rst mid-run: immediate abort, with everything returning to reset values; no done.

## Test plan
- Defaults, len=1, tiles=1, all weights 3, features 1..4: dout_valid[0..3] on successive cycles 2..5 after the beat; dout(b,c)=3*(c+1); done with dout_valid[3].
- len=4, tiles=2, continuous in_valid, weight=-2, feature=7: each column emits -56 twice, 4 cycles apart. No bubble between tiles.
- len=3, in_valid toggling 1,0,1,0,1: single result per column equals the sum of the 3 products, delayed by the gaps.
- SAT=1, O_WIDTH=32, len=4, weight=feature=-32768: saturates to 2^31-1, and ovf=1. The next start clears ovf. SAT=0 wraps to 0 with ovf=0.
- cfg_load and start during RUN, and in_valid in IDLE: ignored, and results are unchanged.
- Assert rst mid-tile, then restart with len=1: all outputs 0 after reset, no done, and fresh results are correct with no stale accumulation.
